// File: rtl/store_xlate_queue.sv
`default_nettype none
// ============================================================================
// Module      : store_xlate_queue
// Description : In-order store queue that translates each head entry
//               through the MMU. The head is then pushed to the store buffer,
//               or retired with an exception writeback.
//               Optional feature macro: STORE_XQ_OFFSET_CHECK_EN (exact
//               page-offset hazard compare instead of the conservative one).
// Revision    : 1.0 - initial release
// ============================================================================
module store_xlate_queue #(
    parameter int XLEN          = 64,
    parameter int VLEN          = 39,
    parameter int PLEN          = 56,
    parameter int DEPTH         = 4,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    // store enqueue
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [VLEN-1:0]            vaddr_i,
    input  logic [XLEN-1:0]            data_i,
    input  logic [XLEN/8-1:0]          be_i,
    input  logic [1:0]                 size_i,
    input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
    // MMU request / response
    output logic                       translation_req_o,
    output logic [VLEN-1:0]            vaddr_o,
    input  logic                       dtlb_hit_i,
    input  logic [PLEN-1:0]            paddr_i,
    input  logic                       ex_valid_i,
    input  logic [5:0]                 ex_cause_i,
    // store buffer push
    output logic                       sb_valid_o,
    input  logic                       sb_ready_i,
    output logic [PLEN-1:0]            sb_paddr_o,
    output logic [XLEN-1:0]            sb_data_o,
    output logic [XLEN/8-1:0]          sb_be_o,
    output logic [1:0]                 sb_size_o,
    // writeback
    output logic                       wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic                       wb_ex_valid_o,
    output logic [5:0]                 wb_ex_cause_o,
    // load hazard check
    input  logic [11:0]                page_offset_i,
    output logic                       page_offset_matches_o,
    // occupancy
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    localparam int SHW     = $clog2(XLEN);
    // Byte-offset bits inside one XLEN word: 3 for XLEN=64, 2 for XLEN=32.
    localparam int OFF_LSB = SHW - 3;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RSP  = 2'd1,
        S_PUSH = 2'd2
    } state_e;

    // Entry storage
    logic [VLEN-1:0]          vaddr_q [DEPTH];
    logic [XLEN-1:0]          data_q  [DEPTH];
    logic [XLEN/8-1:0]        be_q    [DEPTH];
    logic [1:0]               size_q  [DEPTH];
    logic [TRANS_ID_BITS-1:0] tid_q   [DEPTH];
    logic [DEPTH-1:0]         valid_q;

    logic [PW-1:0]   rptr_q, wptr_q;
    logic [CW-1:0]   count_q;
    state_e          state_q, state_d;
    logic [PLEN-1:0] paddr_q, paddr_d;

    logic            w_active;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    logic [SHW-1:0]    w_rot_amt;
    logic [2*XLEN-1:0] w_rot_wide;
    logic [XLEN-1:0]   w_data_rot;

    // Reset and flush both squash every side effect in the current cycle.
    assign w_active = !rst_i && !flush_i;
    assign w_empty  = (count_q == '0);
    assign w_full   = (count_q == CNT_FULL);

    // Back-pressure depends only on occupancy, never on a same-cycle pop.
    assign ready_o  = !w_full;
    assign w_push   = valid_i && !w_full && w_active;

    // Align store data to its byte lane: rotate left by 8 * byte offset.
    assign w_rot_amt  = {vaddr_i[OFF_LSB-1:0], 3'b000};
    assign w_rot_wide = {data_i, data_i} << w_rot_amt;
    assign w_data_rot = w_rot_wide[2*XLEN-1:XLEN];

    // Head-of-queue view
    assign vaddr_o       = vaddr_q[rptr_q];
    assign sb_data_o     = data_q[rptr_q];
    assign sb_be_o       = be_q[rptr_q];
    assign sb_size_o     = size_q[rptr_q];
    assign wb_trans_id_o = tid_q[rptr_q];
    assign count_o       = count_q;

    // Head FSM next-state and the combinational handshake outputs.
    always_comb begin
        state_d           = state_q;
        paddr_d           = paddr_q;
        w_pop             = 1'b0;
        translation_req_o = 1'b0;
        sb_valid_o        = 1'b0;
        sb_paddr_o        = paddr_q;
        wb_valid_o        = 1'b0;
        wb_ex_valid_o     = 1'b0;
        wb_ex_cause_o     = 6'd0;
        if (w_active && !w_empty) begin
            case (state_q)
                S_REQ: begin
                    translation_req_o = 1'b1;
                    if (dtlb_hit_i) begin
                        state_d = S_RSP;
                    end
                end
                S_RSP: begin
                    if (ex_valid_i) begin
                        // Faulting store retires without touching the store buffer.
                        w_pop         = 1'b1;
                        wb_valid_o    = 1'b1;
                        wb_ex_valid_o = 1'b1;
                        wb_ex_cause_o = ex_cause_i;
                        state_d       = S_REQ;
                    end else begin
                        sb_valid_o = 1'b1;
                        sb_paddr_o = paddr_i;
                        if (sb_ready_i) begin
                            w_pop      = 1'b1;
                            wb_valid_o = 1'b1;
                            state_d    = S_REQ;
                        end else begin
                            // MMU result is only valid this cycle; hold it for the retry.
                            paddr_d = paddr_i;
                            state_d = S_PUSH;
                        end
                    end
                end
                S_PUSH: begin
                    sb_valid_o = 1'b1;
                    sb_paddr_o = paddr_q;
                    if (sb_ready_i) begin
                        w_pop      = 1'b1;
                        wb_valid_o = 1'b1;
                        state_d    = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    // Pointers, occupancy, valid bits and FSM state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            state_q <= S_REQ;
            paddr_q <= '0;
        end else if (flush_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
            paddr_q <= paddr_d;
            if (w_pop) begin
                rptr_q          <= rptr_q + PTR_ONE;
                valid_q[rptr_q] <= 1'b0;
            end
            if (w_push) begin
                wptr_q          <= wptr_q + PTR_ONE;
                valid_q[wptr_q] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload write at the tail; contents are qualified by valid_q/count_q.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            vaddr_q[wptr_q] <= vaddr_i;
            data_q[wptr_q]  <= w_data_rot;
            be_q[wptr_q]    <= be_i;
            size_q[wptr_q]  <= size_i;
            tid_q[wptr_q]   <= trans_id_i;
        end
    end

`ifdef STORE_XQ_OFFSET_CHECK_EN
    logic [DEPTH-1:0] w_off_hit;

    // Exact compare of every live entry's word offset against the load's.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_offset_cmp
        assign w_off_hit[gi] = valid_q[gi] &&
            (vaddr_q[gi][11:OFF_LSB] == page_offset_i[11:OFF_LSB]);
    end

    assign page_offset_matches_o = !rst_i && (|w_off_hit);
`else
    logic w_unused_offset;

    // Conservative hazard: any pending store may alias the load.
    assign page_offset_matches_o = !rst_i && !w_empty;
    assign w_unused_offset       = ^{page_offset_i, valid_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_xlate_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_xlate_queue
// Description : Self-checking bench for store_xlate_queue. A queue-based
//               reference model predicts every output each cycle; directed
//               scenarios pin both the DUT and the model to literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_xlate_queue;

    localparam int XLEN  = 64;
    localparam int VLEN  = 39;
    localparam int PLEN  = 56;
    localparam int DEPTH = 4;
    localparam int TIDW  = 3;
    localparam int BW    = XLEN / 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i, flush_i, valid_i, dtlb_hit_i, ex_valid_i, sb_ready_i;
    logic [VLEN-1:0] vaddr_i;
    logic [XLEN-1:0] data_i;
    logic [BW-1:0]   be_i;
    logic [1:0]      size_i;
    logic [TIDW-1:0] trans_id_i;
    logic [PLEN-1:0] paddr_i;
    logic [5:0]      ex_cause_i;
    logic [11:0]     page_offset_i;

    logic            ready_o, translation_req_o, sb_valid_o, wb_valid_o, wb_ex_valid_o;
    logic            page_offset_matches_o;
    logic [VLEN-1:0] vaddr_o;
    logic [PLEN-1:0] sb_paddr_o;
    logic [XLEN-1:0] sb_data_o;
    logic [BW-1:0]   sb_be_o;
    logic [1:0]      sb_size_o;
    logic [TIDW-1:0] wb_trans_id_o;
    logic [5:0]      wb_ex_cause_o;
    logic [CW-1:0]   count_o;

    store_xlate_queue #(
        .XLEN(XLEN), .VLEN(VLEN), .PLEN(PLEN), .DEPTH(DEPTH), .TRANS_ID_BITS(TIDW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .vaddr_i(vaddr_i), .data_i(data_i), .be_i(be_i), .size_i(size_i),
        .trans_id_i(trans_id_i),
        .translation_req_o(translation_req_o), .vaddr_o(vaddr_o),
        .dtlb_hit_i(dtlb_hit_i), .paddr_i(paddr_i),
        .ex_valid_i(ex_valid_i), .ex_cause_i(ex_cause_i),
        .sb_valid_o(sb_valid_o), .sb_ready_i(sb_ready_i),
        .sb_paddr_o(sb_paddr_o), .sb_data_o(sb_data_o), .sb_be_o(sb_be_o),
        .sb_size_o(sb_size_o),
        .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
        .wb_ex_valid_o(wb_ex_valid_o), .wb_ex_cause_o(wb_ex_cause_o),
        .page_offset_i(page_offset_i), .page_offset_matches_o(page_offset_matches_o),
        .count_o(count_o)
    );

    // ------------------------------------------------------------------
    // Reference model: a queue of stores plus the head's progress.
    // head_step: 0 = needs translation, 1 = translation answer arriving,
    //            2 = translated, waiting on the store buffer.
    // ------------------------------------------------------------------
    typedef struct {
        logic [VLEN-1:0] va;
        logic [XLEN-1:0] data;
        logic [BW-1:0]   be;
        logic [1:0]      size;
        logic [TIDW-1:0] tid;
    } ent_t;

    ent_t            mq[$];
    int              head_step = 0;
    logic [PLEN-1:0] held_pa = '0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Expected values for the current cycle (written only by the checker)
    int              e_count;
    bit              e_ready, e_treq, e_sbv, e_wb, e_wbex, e_match;
    logic [5:0]      e_cause;
    logic [PLEN-1:0] e_pa;
    logic [XLEN-1:0] e_data;
    ent_t            e_head;
    ent_t            e_new;
    bit              m_active, m_pop, m_push;
    logic [11:0]     m_off;
    int              m_lsb;

    function automatic logic [XLEN-1:0] rotl_bytes(input logic [XLEN-1:0] d,
                                                   input logic [VLEN-1:0] va);
        int s;
        s = int'(va % BW) * 8;
        if (s == 0) return d;
        return (d << s) | (d >> (XLEN - s));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model by one edge.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            m_active = !rst_i && !flush_i;
            e_count  = mq.size();
            e_ready  = (mq.size() < DEPTH);
            e_treq = 0; e_sbv = 0; e_wb = 0; e_wbex = 0; e_cause = '0; e_pa = '0;
            e_data = '0;
            if (mq.size() > 0) begin
                e_head = mq[0];
                e_data = e_head.data;
            end
            if (m_active && mq.size() > 0) begin
                if (head_step == 0) begin
                    e_treq = 1;
                end else if (head_step == 1) begin
                    if (ex_valid_i) begin
                        e_wb = 1; e_wbex = 1; e_cause = ex_cause_i;
                    end else begin
                        e_sbv = 1; e_pa = paddr_i; e_wb = sb_ready_i;
                    end
                end else begin
                    e_sbv = 1; e_pa = held_pa; e_wb = sb_ready_i;
                end
            end
`ifdef STORE_XQ_OFFSET_CHECK_EN
            m_lsb   = (XLEN == 64) ? 3 : 2;
            e_match = 0;
            foreach (mq[k]) begin
                m_off = mq[k].va[11:0];
                if ((m_off >> m_lsb) == (page_offset_i >> m_lsb)) e_match = 1;
            end
            e_match = e_match && !rst_i;
`else
            e_match = (mq.size() != 0) && !rst_i;
`endif
            chk("count",    64'(count_o),               64'(e_count));
            chk("ready",    64'(ready_o),               64'(e_ready));
            chk("treq",     64'(translation_req_o),     64'(e_treq));
            chk("sb_valid", 64'(sb_valid_o),            64'(e_sbv));
            chk("wb_valid", 64'(wb_valid_o),            64'(e_wb));
            chk("wb_ex",    64'(wb_ex_valid_o),         64'(e_wbex));
            chk("match",    64'(page_offset_matches_o), 64'(e_match));
            if (e_treq) chk("vaddr_o", 64'(vaddr_o), 64'(e_head.va));
            if (e_sbv) begin
                chk("sb_paddr", 64'(sb_paddr_o), 64'(e_pa));
                chk("sb_data",  64'(sb_data_o),  64'(e_head.data));
                chk("sb_be",    64'(sb_be_o),    64'(e_head.be));
                chk("sb_size",  64'(sb_size_o),  64'(e_head.size));
            end
            if (e_wb)   chk("wb_tid",   64'(wb_trans_id_o), 64'(e_head.tid));
            if (e_wbex) chk("wb_cause", 64'(wb_ex_cause_o), 64'(e_cause));

            // Advance the model across the coming clock edge.
            if (rst_i) begin
                mq.delete(); head_step = 0; held_pa = '0;
            end else if (flush_i) begin
                mq.delete(); head_step = 0;
            end else begin
                m_pop  = 0;
                m_push = valid_i && (mq.size() < DEPTH);
                if (mq.size() > 0) begin
                    if (head_step == 0) begin
                        if (dtlb_hit_i) head_step = 1;
                    end else if (head_step == 1) begin
                        if (ex_valid_i || sb_ready_i) begin
                            m_pop = 1; head_step = 0;
                        end else begin
                            held_pa = paddr_i; head_step = 2;
                        end
                    end else if (sb_ready_i) begin
                        m_pop = 1; head_step = 0;
                    end
                end
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    e_new.va   = vaddr_i;
                    e_new.data = rotl_bytes(data_i, vaddr_i);
                    e_new.be   = be_i;
                    e_new.size = size_i;
                    e_new.tid  = trans_id_i;
                    mq.push_back(e_new);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle();
        rst_i = 0; flush_i = 0; valid_i = 0; vaddr_i = '0; data_i = '0; be_i = '0;
        size_i = '0; trans_id_i = '0; dtlb_hit_i = 0; paddr_i = '0; ex_valid_i = 0;
        ex_cause_i = '0; sb_ready_i = 0; page_offset_i = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    task automatic do_reset();
        tick();
        rst_i = 1;
    endtask

    int              wb_n;
    logic [VLEN-1:0] last_va;

    initial begin
        idle();
        rst_i = 1;
        @(negedge clk);
        chk_en = 1;
        rst_i  = 1;

        // Single store, byte offset 3, immediate store-buffer accept.
        tick(); valid_i = 1; vaddr_i = 39'h1003; data_i = 64'hAB; be_i = 8'h01;
        size_i = 2'd0; trans_id_i = 3'd5;
        #2;
        chk("lit_rst_count", 64'(count_o), 64'd0);
        chk("lit_rst_ready", 64'(ready_o), 64'd1);
        tick(); dtlb_hit_i = 1;
        #2;
        chk("lit_treq",  64'(translation_req_o), 64'd1);
        chk("lit_vaddr", 64'(vaddr_o), 64'h1003);
        tick(); paddr_i = 56'h8000_1003; sb_ready_i = 1;
        #2;
        chk("lit_sb_valid",   64'(sb_valid_o), 64'd1);
        chk("lit_sb_data",    64'(sb_data_o),  64'hAB00_0000);
        chk("lit_model_data", 64'(e_data),     64'hAB00_0000);
        chk("lit_sb_paddr",   64'(sb_paddr_o), 64'h8000_1003);
        chk("lit_wb_valid",   64'(wb_valid_o), 64'd1);
        chk("lit_model_wb",   64'(e_wb),       64'd1);
        chk("lit_wb_tid",     64'(wb_trans_id_o), 64'd5);
        tick();
        #2;
        chk("lit_empty_count", 64'(count_o), 64'd0);
        chk("lit_empty_treq",  64'(translation_req_o), 64'd0);

        // Fill to DEPTH with the store buffer stalled, then drain.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(); valid_i = 1; vaddr_i = VLEN'(64'h40 + 8 * i);
            data_i = 64'(i + 1); be_i = 8'hFF; size_i = 2'd3; trans_id_i = TIDW'(i);
            dtlb_hit_i = 1;
        end
        tick(); dtlb_hit_i = 1;
        #2;
        chk("lit_full_count", 64'(count_o), 64'd4);
        chk("lit_full_ready", 64'(ready_o), 64'd0);
        wb_n = 0;
        for (int c = 0; c < 10; c++) begin
            tick(); dtlb_hit_i = 1; sb_ready_i = 1; paddr_i = PLEN'(64'h1000 + c);
            #2;
            if (wb_valid_o) begin
                chk("lit_drain_tid",   64'(wb_trans_id_o), 64'(wb_n));
                chk("lit_drain_cycle", 64'(c), 64'(2 * wb_n));
                wb_n++;
            end
        end
        chk("lit_drain_total", 64'(wb_n), 64'd4);

        // Translation exception on the head, next entry follows.
        do_reset();
        tick(); valid_i = 1; vaddr_i = 39'h100; trans_id_i = 3'd1;
        tick(); valid_i = 1; vaddr_i = 39'h208; trans_id_i = 3'd2; dtlb_hit_i = 1;
        tick(); ex_valid_i = 1; ex_cause_i = 6'd15; paddr_i = 56'h5; sb_ready_i = 1;
        #2;
        chk("lit_ex_sb_valid", 64'(sb_valid_o),    64'd0);
        chk("lit_ex_wb",       64'(wb_valid_o),    64'd1);
        chk("lit_ex_valid",    64'(wb_ex_valid_o), 64'd1);
        chk("lit_ex_cause",    64'(wb_ex_cause_o), 64'd15);
        chk("lit_ex_model",    64'(e_cause),       64'd15);
        chk("lit_ex_tid",      64'(wb_trans_id_o), 64'd1);
        tick();
        #2;
        chk("lit_ex_next_treq",  64'(translation_req_o), 64'd1);
        chk("lit_ex_next_vaddr", 64'(vaddr_o), 64'h208);

        // Flush while the head waits on the store buffer.
        do_reset();
        tick(); valid_i = 1; vaddr_i = 39'h10; trans_id_i = 3'd3;
        tick(); valid_i = 1; vaddr_i = 39'h18; trans_id_i = 3'd4; dtlb_hit_i = 1;
        tick(); valid_i = 1; vaddr_i = 39'h20; trans_id_i = 3'd5; paddr_i = 56'h77;
        tick(); flush_i = 1; sb_ready_i = 1; valid_i = 1;
        #2;
        chk("lit_fl_count", 64'(count_o),    64'd3);
        chk("lit_fl_sb",    64'(sb_valid_o), 64'd0);
        chk("lit_fl_wb",    64'(wb_valid_o), 64'd0);
        tick();
        #2;
        chk("lit_fl_after", 64'(count_o), 64'd0);

        // Page-offset hazard check.
        do_reset();
        tick(); valid_i = 1; vaddr_i = 39'h2A48; trans_id_i = 3'd6;
        tick(); page_offset_i = 12'hA4C;
        #2;
        chk("lit_match_hit", 64'(page_offset_matches_o), 64'd1);
        tick(); page_offset_i = 12'hA50;
        #2;
`ifdef STORE_XQ_OFFSET_CHECK_EN
        chk("lit_match_miss", 64'(page_offset_matches_o), 64'd0);
`else
        chk("lit_match_miss", 64'(page_offset_matches_o), 64'd1);
`endif

        // Randomized traffic against the model.
        do_reset();
        last_va = '0;
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst_i      = ($urandom_range(0, 199) == 0);
            flush_i    = ($urandom_range(0, 49) == 0);
            valid_i    = $urandom_range(0, 1);
            vaddr_i    = VLEN'({$urandom(), $urandom()});
            data_i     = {$urandom(), $urandom()};
            be_i       = BW'($urandom());
            size_i     = 2'($urandom());
            trans_id_i = TIDW'($urandom());
            dtlb_hit_i = ($urandom_range(0, 9) < 6);
            paddr_i    = PLEN'({$urandom(), $urandom()});
            ex_valid_i = ($urandom_range(0, 9) < 2);
            ex_cause_i = 6'($urandom());
            sb_ready_i = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) page_offset_i = last_va[11:0] ^ 12'($urandom_range(0, 15));
            else                           page_offset_i = 12'($urandom());
            if (valid_i) last_va = vaddr_i;
        end

        tick();
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
